exc_ctrl: RTL
=============

# exc_ctrl

Exception/interrupt sequencer between the MEM stage and CP0. It samples per-instruction exception flags and CP0 status/cause, picks one event by fixed priority, drives CP0's exception-type/EPC/BadVAddr inputs for exactly one cycle, then flushes the pipeline and issues a PC redirect through a valid/ready handshake. This makes CP0 state updates, the flush and the refetch a single atomic, ordered sequence.

## Interface
- No parameters; all widths and codes come from the shared package.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- mem_valid  in  1  MEM stage holds a real instruction
- mem_stall  in  1  MEM stage stalled this cycle
- mem_exc  in  8  flags {ades, adel_d, sys, bp, ov, ri, adel_if, eret}, bit7..bit0
- mem_pc  in  32  PC of MEM instruction
- mem_delayslot  in  1  MEM instruction is in a delay slot
- mem_badvaddr  in  32  faulting data address
- cp0_status, cp0_cause, cp0_epc, cp0_ebase  in  32 each  CP0 outputs
- exc_type  out  4  encoded event to CP0; 0 = none
- exc_pc  out  32  PC to CP0 (CP0 applies the delay-slot -4)
- exc_delayslot  out  1  to CP0
- exc_badvaddr  out  32  to CP0
- flush  out  1  kill IF..MEM
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  state != IDLE

## Operation
- Interrupt pending: `int_pend = status[0] & ~status[1] & |(status[15:8] & cause[15:8])`, i.e. IE set, EXL clear, and at least one IM/IP bit pair set. An interrupt attaches only to a valid MEM instruction.
- Trigger: IDLE & mem_valid & ~mem_stall & (int_pend | |mem_exc).
- Priority, high to low: INT, ADEL_IF, RI, OV, BP, SYS, ADEL_D, ADES, ERET. Only the winner is reported.
- Codes: NONE=0, INT=1, IF=2, ADEL=3, RI=4, OV=5, BP=6, SYS=7, ADES=8, ERET=9.
- BadVAddr: mem_pc for ADEL_IF, mem_badvaddr for ADEL_D/ADES, 0 otherwise.
- FSM states:
  - IDLE: on trigger, latch code, pc, delayslot and badvaddr, then go to COMMIT.
  - COMMIT: drive exc_* from the latches for exactly one cycle; assert flush; compute the target (ERET → cp0_epc sampled this cycle; otherwise vector); go to REDIRECT.
  - REDIRECT: assert flush and redirect_valid; hold redirect_pc stable; on redirect_ready go to IDLE.
- exc_type, exc_pc, exc_delayslot and exc_badvaddr are 0 outside COMMIT.
- Vector: {cp0_ebase[31:12], 12'h180}, 32-bit, no carry beyond bit 11.
- Triggers arriving while busy are ignored; the flushed pipeline re-presents them.
- mem_stall with pending flags: no action until the stall clears.

## Timing
- Reset (rst=0 at a clk edge): state IDLE; all outputs 0; latches cleared. Reset mid-sequence aborts immediately with no redirect.
- Trigger at cycle t: exc_type valid in t+1 (CP0 updates at the end of t+1). redirect_valid rises at t+2.
- Minimum sequence is 3 cycles (ready already high at t+2).
- flush is high from t+1 through the cycle in which redirect_ready is sampled high.
- A trigger is possible again in the cycle after returning to IDLE.
- The interrupt is evaluated on the cp0_* values present at cycle t. A CP0 write in t is not visible until t+1.

## Configuration
- EXC_CTRL_BEV_EN:
  - Defined: if cp0_status[22] (BEV)=1, the vector is 32'hBFC00380; otherwise the ebase vector.
  - Undefined: BEV is ignored and the ebase vector is always used.
- ERET is unaffected either way.

## Structure
- Shared package/header: exception code constants (EXC_CODE_*), mem_exc bit positions, the state encoding, the vector offset 12'h180, the BEV vector, and CP0 field positions (IE, EXL, IM, IP, BEV).
- One natural sub-module: exc_prio_enc, a combinational priority encoder from {int_pend, mem_exc} to the 4-bit code and badvaddr select.
- FSM, latches and handshake stay in exc_ctrl.

## Test plan
- SYS at pc=0x8000_1000, not in a delay slot, ebase=0x8000_0000, ready=1 → exc_type=7 and exc_pc=0x8000_1000 at t+1; redirect_pc=0x8000_0180 at t+2; flush high t+1..t+2.
- status=0x0000_0401, cause IP2 set, SYS and OV flags both set → exc_type=1 (INT wins).
- Same as the previous case but status EXL=1 → INT masked; exc_type=5 (OV).
- ERET with cp0_epc=0x8000_2004, redirect_ready low for 3 cycles → redirect_valid and redirect_pc=0x8000_2004 held stable; back to IDLE one cycle after ready.
- ADES, mem_badvaddr=0x1235, delayslot=1 → exc_type=8, exc_badvaddr=0x1235, exc_delayslot=1. A second trigger during REDIRECT produces no new exc_type.
- rst=0 asserted in REDIRECT → next cycle all outputs 0, busy=0. With EXC_CTRL_BEV_EN and status[22]=1 → redirect_pc=0xBFC0_0380.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: event codes, mem_exc flag
// positions, FSM encoding, vector constants and CP0 field positions.
package exc_ctrl_pkg;

  localparam logic [3:0] EXC_CODE_NONE = 4'd0;
  localparam logic [3:0] EXC_CODE_INT  = 4'd1;
  localparam logic [3:0] EXC_CODE_IF   = 4'd2;
  localparam logic [3:0] EXC_CODE_ADEL = 4'd3;
  localparam logic [3:0] EXC_CODE_RI   = 4'd4;
  localparam logic [3:0] EXC_CODE_OV   = 4'd5;
  localparam logic [3:0] EXC_CODE_BP   = 4'd6;
  localparam logic [3:0] EXC_CODE_SYS  = 4'd7;
  localparam logic [3:0] EXC_CODE_ADES = 4'd8;
  localparam logic [3:0] EXC_CODE_ERET = 4'd9;

  localparam int unsigned EXC_BIT_ERET    = 0;
  localparam int unsigned EXC_BIT_ADEL_IF = 1;
  localparam int unsigned EXC_BIT_RI      = 2;
  localparam int unsigned EXC_BIT_OV      = 3;
  localparam int unsigned EXC_BIT_BP      = 4;
  localparam int unsigned EXC_BIT_SYS     = 5;
  localparam int unsigned EXC_BIT_ADEL_D  = 6;
  localparam int unsigned EXC_BIT_ADES    = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_DATA
  } badv_sel_e;

  localparam logic [11:0] EXC_VEC_OFFSET = 12'h180;
  localparam logic [31:0] EXC_BEV_VECTOR = 32'hBFC0_0380;

  localparam int unsigned CP0_STATUS_IE  = 0;
  localparam int unsigned CP0_STATUS_EXL = 1;
  localparam int unsigned CP0_STATUS_BEV = 22;
  localparam int unsigned CP0_IM_LSB     = 8;
  localparam int unsigned CP0_IM_MSB     = 15;
  localparam int unsigned CP0_IP_LSB     = 8;
  localparam int unsigned CP0_IP_MSB     = 15;

  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[CP0_STATUS_IE] & ~status[CP0_STATUS_EXL] &
           (|(status[CP0_IM_MSB:CP0_IM_LSB] & cause[CP0_IP_MSB:CP0_IP_LSB]));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: picks one event from {int_pend, mem_exc} and selects
// the BadVAddr source for it.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_pend_i,
  input  logic [7:0] exc_i,
  output logic [3:0] code_o,
  output badv_sel_e  badv_sel_o
);

  always_comb begin
    code_o     = EXC_CODE_NONE;
    badv_sel_o = BADV_NONE;
    if (int_pend_i) begin
      code_o = EXC_CODE_INT;
    end else if (exc_i[EXC_BIT_ADEL_IF]) begin
      code_o     = EXC_CODE_IF;
      badv_sel_o = BADV_PC;
    end else if (exc_i[EXC_BIT_RI]) begin
      code_o = EXC_CODE_RI;
    end else if (exc_i[EXC_BIT_OV]) begin
      code_o = EXC_CODE_OV;
    end else if (exc_i[EXC_BIT_BP]) begin
      code_o = EXC_CODE_BP;
    end else if (exc_i[EXC_BIT_SYS]) begin
      code_o = EXC_CODE_SYS;
    end else if (exc_i[EXC_BIT_ADEL_D]) begin
      code_o     = EXC_CODE_ADEL;
      badv_sel_o = BADV_DATA;
    end else if (exc_i[EXC_BIT_ADES]) begin
      code_o     = EXC_CODE_ADES;
      badv_sel_o = BADV_DATA;
    end else if (exc_i[EXC_BIT_ERET]) begin
      code_o = EXC_CODE_ERET;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: IDLE -> COMMIT (one-cycle CP0 update) ->
// REDIRECT (flush + PC redirect handshake). Optional macro: EXC_CTRL_BEV_EN.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [7:0]  mem_exc,
  input  logic [31:0] mem_pc,
  input  logic        mem_delayslot,
  input  logic [31:0] mem_badvaddr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_ebase,
  output logic [3:0]  exc_type,
  output logic [31:0] exc_pc,
  output logic        exc_delayslot,
  output logic [31:0] exc_badvaddr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  state_e      state_q;
  logic [3:0]  exc_type_q;
  logic [31:0] exc_pc_q;
  logic        exc_ds_q;
  logic [31:0] exc_badv_q;
  logic        flush_q;
  logic        rvalid_q;
  logic [31:0] rpc_q;
  logic        busy_q;

  logic        int_pend;
  logic        trigger;
  logic [3:0]  code;
  badv_sel_e   badv_sel;
  logic [31:0] badv_d;
  logic [31:0] vector;
  logic [31:0] target_d;
  logic        unused_cp0;

  assign int_pend = int_pending(cp0_status, cp0_cause);
  assign trigger  = (state_q == ST_IDLE) & mem_valid & ~mem_stall &
                    (int_pend | (|mem_exc));

  exc_prio_enc u_prio (
    .int_pend_i (int_pend),
    .exc_i      (mem_exc),
    .code_o     (code),
    .badv_sel_o (badv_sel)
  );

  always_comb begin
    badv_d = '0;
    case (badv_sel)
      BADV_PC:   badv_d = mem_pc;
      BADV_DATA: badv_d = mem_badvaddr;
      default:   badv_d = '0;
    endcase
  end

`ifdef EXC_CTRL_BEV_EN
  assign vector = cp0_status[CP0_STATUS_BEV] ? EXC_BEV_VECTOR
                                             : {cp0_ebase[31:12], EXC_VEC_OFFSET};
`else
  assign vector = {cp0_ebase[31:12], EXC_VEC_OFFSET};
`endif

  // ERET target is taken from cp0_epc as seen during COMMIT, not at trigger time.
  assign target_d = (exc_type_q == EXC_CODE_ERET) ? cp0_epc : vector;

  assign unused_cp0 = ^{cp0_status, cp0_cause, cp0_ebase[11:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      exc_type_q <= '0;
      exc_pc_q   <= '0;
      exc_ds_q   <= 1'b0;
      exc_badv_q <= '0;
      flush_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rpc_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q    <= ST_COMMIT;
            exc_type_q <= code;
            exc_pc_q   <= mem_pc;
            exc_ds_q   <= mem_delayslot;
            exc_badv_q <= badv_d;
            flush_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state_q    <= ST_REDIRECT;
          exc_type_q <= '0;
          exc_pc_q   <= '0;
          exc_ds_q   <= 1'b0;
          exc_badv_q <= '0;
          rvalid_q   <= 1'b1;
          rpc_q      <= target_d;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state_q  <= ST_IDLE;
            flush_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rpc_q    <= '0;
            busy_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign exc_type       = exc_type_q;
  assign exc_pc         = exc_pc_q;
  assign exc_delayslot  = exc_ds_q;
  assign exc_badvaddr   = exc_badv_q;
  assign flush          = flush_q;
  assign redirect_valid = rvalid_q;
  assign redirect_pc    = rpc_q;
  assign busy           = busy_q;

endmodule
